offnariscv_pipe_tracer: RTL and testbench
=========================================

OFFNARISCV_PIPE_TRACER -- requirements
Module: offnariscv_pipe_tracer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of traced pipeline stages (legal 2..8).
REQ-002 SHALL have parameter ID_WIDTH, default 16, instruction-ID and retire-sequence width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, record FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter DELTA_WIDTH, default 8, cycle-delta field width.
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have inputs: fetch_start 1 (new instruction issued); stage_ack NUM_STAGES (per-stage handshake); stage_id NUM_STAGES*ID_WIDTH (ID per stage, stage s at bits [s*ID_WIDTH +: ID_WIDTH]).
REQ-007 SHALL have inputs: retire_valid 1; retire_id ID_WIDTH; flush_valid 1; flush_id ID_WIDTH (last surviving ID).
REQ-008 SHALL have output stream rec_valid out 1, rec_ready in 1, and payload outputs rec_kind 1 (0 activity, 1 overflow marker), rec_delta DELTA_WIDTH, rec_start 1, rec_start_id ID_WIDTH, rec_stage_mask NUM_STAGES, rec_stage_id NUM_STAGES*ID_WIDTH, rec_retire 1, rec_retire_id ID_WIDTH, rec_retire_seq ID_WIDTH, rec_flush 1, rec_flush_first ID_WIDTH, rec_flush_last ID_WIDTH, rec_drop_cnt 16.
REQ-009 SHALL have status output dropping 1 (high while in DROP state).

Function
REQ-010 SHALL keep next_id counter: on fetch_start, record rec_start_id = next_id, then next_id+1 modulo 2^ID_WIDTH.
REQ-011 SHALL keep retire_seq counter: retire record carries current retire_seq, counter +1; a flush then advances it by range length; both modulo 2^ID_WIDTH.
REQ-012 SHALL compute flush range: first = flush_id+1, last = next_id-1 (next_id before same-cycle start); range empty when first == next_id, then rec_flush=0 and retire_seq unchanged.
REQ-013 Same-cycle start with flush SHALL give the new instruction ID next_id (not flushed); same-cycle retire is sequenced before flush.
REQ-014 An active cycle (any of fetch_start, stage_ack, retire_valid, nonempty flush) SHALL produce exactly one activity record capturing all events of that cycle; stage IDs for unacked stages SHALL be 0.
REQ-015 SHALL keep delta counter: counts cycles since last enqueued record, saturates at 2^DELTA_WIDTH-1; enqueued record carries counter value; counter restarts at 1 the following cycle.
REQ-016 Record written in cycle N SHALL appear on rec_valid no earlier than N+1; pop on rec_valid && rec_ready; payload stable while rec_valid && !rec_ready; order preserved.
REQ-017 Full SHALL be evaluated on registered occupancy; a same-cycle pop SHALL NOT free space for a same-cycle write.
REQ-018 FSM NORMAL: active cycle with FIFO not full -> enqueue; active cycle with FIFO full -> drop record, drop_cnt=1, go DROP.
REQ-019 FSM DROP: active cycles while full -> drop_cnt+1 saturating at 65535; when not full -> enqueue marker (rec_kind=1, rec_drop_cnt = drop_cnt, plus 1 if current cycle active; other payload 0), go NORMAL.
REQ-020 next_id, retire_seq and delta SHALL continue updating while dropping; marker enqueue restarts delta.

Reset
REQ-021 rst low SHALL asynchronously clear FIFO, next_id, retire_seq, drop_cnt to 0, delta to 0, FSM to NORMAL; rec_valid=0, dropping=0, all rec_* payload 0.
REQ-022 Release SHALL be synchronised internally; first record cannot appear before second clk edge after release; reset mid-stream discards all queued records.

Verification
REQ-023 Reset, fetch_start one cycle at cycle 3 -> one record rec_start=1, rec_start_id=0, rec_delta=3.
REQ-024 NUM_STAGES=5, stage_ack=5'b10101, IDs 7/0/5/0/3, retire_valid id 2 same cycle -> single record mask 10101, IDs preserved, rec_retire_seq=0.
REQ-025 next_id=10, flush_id=6 with fetch_start -> rec_flush_first=7, last=9, rec_start_id=10; next retire seq advanced by 3.
REQ-026 FIFO_DEPTH=8, rec_ready=0, 12 consecutive active cycles -> 8 records queued, dropping=1; raise rec_ready -> 8 records, then marker rec_drop_cnt>=4 covering every active cycle not recorded.
REQ-027 Idle 300 cycles, DELTA_WIDTH=8, then activity -> rec_delta=255; next_id at 16'hFFFF with start -> id FFFF then wraps to 0.

Source files
------------

// File: rtl/offnariscv_pipe_tracer.sv
// Pipeline tracer: turns per-cycle pipeline events (fetch, stage handshakes,
// retire, flush) into compact trace records queued in a small FIFO. When the
// FIFO fills, records are dropped and counted; once space returns, a single
// overflow marker reports how many activity records were lost.
//
// Output stream handshake: a record is offered while rec_valid is high and is
// consumed on a clock edge where rec_valid && rec_ready. While rec_valid is
// high and rec_ready is low, the payload holds steady. rec_valid never depends
// combinationally on rec_ready.
//
// The `dropping` output is the registered view of the NORMAL/DROP state.

module offnariscv_pipe_tracer #(
    parameter int NUM_STAGES  = 5,
    parameter int ID_WIDTH    = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int DELTA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fetch_start,
    input  logic [NUM_STAGES-1:0]          stage_ack,
    input  logic [NUM_STAGES*ID_WIDTH-1:0] stage_id,
    input  logic                           retire_valid,
    input  logic [ID_WIDTH-1:0]            retire_id,
    input  logic                           flush_valid,
    input  logic [ID_WIDTH-1:0]            flush_id,
    output logic                           rec_valid,
    input  logic                           rec_ready,
    output logic                           rec_kind,
    output logic [DELTA_WIDTH-1:0]         rec_delta,
    output logic                           rec_start,
    output logic [ID_WIDTH-1:0]            rec_start_id,
    output logic [NUM_STAGES-1:0]          rec_stage_mask,
    output logic [NUM_STAGES*ID_WIDTH-1:0] rec_stage_id,
    output logic                           rec_retire,
    output logic [ID_WIDTH-1:0]            rec_retire_id,
    output logic [ID_WIDTH-1:0]            rec_retire_seq,
    output logic                           rec_flush,
    output logic [ID_WIDTH-1:0]            rec_flush_first,
    output logic [ID_WIDTH-1:0]            rec_flush_last,
    output logic [15:0]                    rec_drop_cnt,
    output logic                           dropping
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int REC_W = 1 + DELTA_WIDTH + 1 + ID_WIDTH + NUM_STAGES
                         + NUM_STAGES*ID_WIDTH + 1 + 2*ID_WIDTH + 1
                         + 2*ID_WIDTH + 16;

    localparam logic [ID_WIDTH-1:0]    ID_ONE    = {{(ID_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DELTA_WIDTH-1:0] DELTA_ONE = {{(DELTA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DELTA_WIDTH-1:0] DELTA_MAX = {DELTA_WIDTH{1'b1}};
    localparam logic [AW-1:0]          PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]            CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]            CNT_FULL  = {1'b1, {AW{1'b0}}};

    typedef enum logic {ST_NORMAL, ST_DROP} state_t;

    state_t                     state_q;
    logic [1:0]                 rst_sync;
    logic                       rst_n_i;
    logic [ID_WIDTH-1:0]        next_id_q, retire_seq_q;
    logic [DELTA_WIDTH-1:0]     delta_q;
    logic [15:0]                drop_cnt_q, drop_inc, marker_cnt;
    logic [ID_WIDTH-1:0]        flush_first, flush_last, flush_len, seq_after_ret;
    logic                       flush_hit, active, full, wr_en, pop;
    logic [NUM_STAGES*ID_WIDTH-1:0] stage_id_m;
    logic [REC_W-1:0]           act_rec, marker_rec, wr_data, rec_out;
    logic [REC_W-1:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [AW:0]                count_q;

    // Reset asserts immediately and releases two clock edges later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_i = rst_sync[1];

    // Flush covers flush_id+1 .. next_id-1; empty when flush_id is the newest ID
    assign flush_first   = flush_id + ID_ONE;
    assign flush_last    = next_id_q - ID_ONE;
    assign flush_len     = next_id_q - flush_first;
    assign flush_hit     = flush_valid && (flush_first != next_id_q);
    assign active        = fetch_start || (|stage_ack) || retire_valid || flush_hit;
    assign seq_after_ret = retire_valid ? retire_seq_q + ID_ONE : retire_seq_q;
    assign full          = (count_q == CNT_FULL);
    assign drop_inc      = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
    assign marker_cnt    = active ? drop_inc : drop_cnt_q;

    // Unacknowledged stages report ID 0
    always_comb begin
        stage_id_m = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (stage_ack[s]) stage_id_m[s*ID_WIDTH +: ID_WIDTH] = stage_id[s*ID_WIDTH +: ID_WIDTH];
        end
    end

    assign act_rec = {1'b0, delta_q,
                      fetch_start, fetch_start ? next_id_q : '0,
                      stage_ack, stage_id_m,
                      retire_valid, retire_valid ? retire_id : '0,
                      retire_valid ? retire_seq_q : '0,
                      flush_hit, flush_hit ? flush_first : '0,
                      flush_hit ? flush_last : '0,
                      16'd0};
    assign marker_rec = {1'b1, {(REC_W-17){1'b0}}, marker_cnt};

    // Choose what (if anything) enters the FIFO this cycle
    always_comb begin
        wr_en   = 1'b0;
        wr_data = act_rec;
        if (state_q == ST_NORMAL) begin
            wr_en = active && !full;
        end else if (!full) begin
            wr_en   = 1'b1;
            wr_data = marker_rec;
        end
    end

    // Overflow FSM: count lost activity records until the FIFO has room
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_NORMAL;
            drop_cnt_q <= 16'd0;
            dropping   <= 1'b0;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    if (active && full) begin
                        state_q    <= ST_DROP;
                        drop_cnt_q <= 16'd1;
                        dropping   <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (full) begin
                        if (active) drop_cnt_q <= drop_inc;
                    end else begin
                        state_q    <= ST_NORMAL;
                        drop_cnt_q <= 16'd0;
                        dropping   <= 1'b0;
                    end
                end
                default: state_q <= ST_NORMAL;
            endcase
        end
    end

    // ID, retire sequence and delta counters run regardless of drops
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            next_id_q    <= '0;
            retire_seq_q <= '0;
            delta_q      <= '0;
        end else begin
            if (fetch_start) next_id_q <= next_id_q + ID_ONE;
            retire_seq_q <= flush_hit ? seq_after_ret + flush_len : seq_after_ret;
            if (wr_en)                   delta_q <= DELTA_ONE;
            else if (delta_q != DELTA_MAX) delta_q <= delta_q + DELTA_ONE;
        end
    end

    assign rec_valid = (count_q != '0);
    assign pop       = rec_valid && rec_ready;

    // FIFO pointers and registered occupancy
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are only visible through the valid-gated head
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

    assign rec_out = rec_valid ? mem[rd_ptr_q] : '0;
    assign {rec_kind, rec_delta, rec_start, rec_start_id, rec_stage_mask,
            rec_stage_id, rec_retire, rec_retire_id, rec_retire_seq,
            rec_flush, rec_flush_first, rec_flush_last, rec_drop_cnt} = rec_out;

endmodule

// File: tb/tb_offnariscv_pipe_tracer.sv
// Directed bench for offnariscv_pipe_tracer: stimulus pushes hand-computed
// records into a queue, a monitor pops and compares on every stream transfer.

module tb_offnariscv_pipe_tracer;

    localparam int NS    = 5;
    localparam int IW    = 16;
    localparam int FD    = 8;
    localparam int DW    = 8;
    localparam int REC_W = 1 + DW + 1 + IW + NS + NS*IW + 1 + IW + IW + 1 + IW + IW + 16;

    logic              clk, rst;
    logic              fetch_start, retire_valid, flush_valid, rec_ready;
    logic [NS-1:0]     stage_ack;
    logic [NS*IW-1:0]  stage_id;
    logic [IW-1:0]     retire_id, flush_id;
    logic              rec_valid, rec_kind, rec_start, rec_retire, rec_flush, dropping;
    logic [DW-1:0]     rec_delta;
    logic [IW-1:0]     rec_start_id, rec_retire_id, rec_retire_seq, rec_flush_first, rec_flush_last;
    logic [NS-1:0]     rec_stage_mask;
    logic [NS*IW-1:0]  rec_stage_id;
    logic [15:0]       rec_drop_cnt;

    int errors = 0;
    int checks = 0;
    int rec_idx = 0;
    logic [REC_W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    offnariscv_pipe_tracer #(
        .NUM_STAGES(NS), .ID_WIDTH(IW), .FIFO_DEPTH(FD), .DELTA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_start(fetch_start), .stage_ack(stage_ack), .stage_id(stage_id),
        .retire_valid(retire_valid), .retire_id(retire_id),
        .flush_valid(flush_valid), .flush_id(flush_id),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_kind(rec_kind), .rec_delta(rec_delta),
        .rec_start(rec_start), .rec_start_id(rec_start_id),
        .rec_stage_mask(rec_stage_mask), .rec_stage_id(rec_stage_id),
        .rec_retire(rec_retire), .rec_retire_id(rec_retire_id), .rec_retire_seq(rec_retire_seq),
        .rec_flush(rec_flush), .rec_flush_first(rec_flush_first), .rec_flush_last(rec_flush_last),
        .rec_drop_cnt(rec_drop_cnt), .dropping(dropping)
    );

    // ---------------- record helpers ----------------
    function automatic logic [REC_W-1:0] pack_rec(
        input logic k, input logic [DW-1:0] d, input logic st, input logic [IW-1:0] sid,
        input logic [NS-1:0] m, input logic [NS*IW-1:0] sids,
        input logic rt, input logic [IW-1:0] rid, input logic [IW-1:0] rseq,
        input logic fl, input logic [IW-1:0] ffirst, input logic [IW-1:0] flast,
        input logic [15:0] dc);
        return {k, d, st, sid, m, sids, rt, rid, rseq, fl, ffirst, flast, dc};
    endfunction

    function automatic logic [REC_W-1:0] exp_start(input logic [DW-1:0] d, input logic [IW-1:0] sid);
        return pack_rec(1'b0, d, 1'b1, sid, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 16'd0);
    endfunction

    function automatic logic [REC_W-1:0] exp_retire(input logic [DW-1:0] d, input logic [IW-1:0] rid,
                                                     input logic [IW-1:0] seq);
        return pack_rec(1'b0, d, 1'b0, '0, '0, '0, 1'b1, rid, seq, 1'b0, '0, '0, 16'd0);
    endfunction

    function automatic logic [REC_W-1:0] dut_rec();
        return pack_rec(rec_kind, rec_delta, rec_start, rec_start_id, rec_stage_mask, rec_stage_id,
                        rec_retire, rec_retire_id, rec_retire_seq, rec_flush,
                        rec_flush_first, rec_flush_last, rec_drop_cnt);
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic             prev_stall;
        logic [REC_W-1:0] prev_rec, act, exp;
        prev_stall = 1'b0;
        prev_rec   = '0;
        forever begin
            @(negedge clk);
            #2;
            act = dut_rec();
            if (prev_stall && rec_valid) begin
                checks++;
                if (act !== prev_rec) begin
                    errors++;
                    $display("FAIL stall_hold: got %h expected %h", act, prev_rec);
                end
            end
            if (rec_valid && rec_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rec[%0d]: got %h expected none", rec_idx, act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL rec[%0d]: got %h expected %h", rec_idx, act, exp);
                    end
                end
                rec_idx++;
            end
            prev_stall = rec_valid && !rec_ready;
            prev_rec   = act;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic fs, input logic [NS-1:0] ack, input logic [NS*IW-1:0] ids,
                       input logic rv, input logic [IW-1:0] rid,
                       input logic fv, input logic [IW-1:0] fid);
        fetch_start  = fs;
        stage_ack    = ack;
        stage_id     = ids;
        retire_valid = rv;
        retire_id    = rid;
        flush_valid  = fv;
        flush_id     = fid;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic fetch();
        cyc(1'b1, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            idle(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d records outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b0;
        rec_ready = 1'b1;
        fetch_start = 1'b0; stage_ack = '0; stage_id = '0;
        retire_valid = 1'b0; retire_id = '0; flush_valid = 1'b0; flush_id = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_valid", 32'(rec_valid), 32'd0);
        check_val("rst_dropping", 32'(dropping), 32'd0);
        check_val("rst_start_id", 32'(rec_start_id), 32'd0);
        check_val("rst_drop_cnt", 32'(rec_drop_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // two synchroniser cycles, then cycles 0..2 idle, fetch in cycle 3
        idle(5);
        exp_q.push_back(exp_start(8'd3, 16'd0));
        fetch();

        // stage handshakes with retire in the same cycle; unacked IDs read 0
        exp_q.push_back(pack_rec(1'b0, 8'd1, 1'b0, '0, 5'b10101,
                                 {16'd3, 16'd0, 16'd5, 16'd0, 16'd7},
                                 1'b1, 16'd2, 16'd0, 1'b0, '0, '0, 16'd0));
        cyc(1'b0, 5'b10101, {16'd3, 16'hBEEF, 16'd5, 16'hDEAD, 16'd7}, 1'b1, 16'd2, 1'b0, '0);

        // bring next_id to 10
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back(exp_start(8'd1, IW'(i)));
            fetch();
        end

        // flush after ID 6 with a new fetch: range 7..9, new ID 10 survives
        exp_q.push_back(pack_rec(1'b0, 8'd1, 1'b1, 16'd10, '0, '0,
                                 1'b0, '0, '0, 1'b1, 16'd7, 16'd9, 16'd0));
        cyc(1'b1, '0, '0, 1'b0, '0, 1'b1, 16'd6);
        // retire_seq was 1, advanced by 3
        exp_q.push_back(exp_retire(8'd1, 16'd7, 16'd4));
        cyc(1'b0, '0, '0, 1'b1, 16'd7, 1'b0, '0);

        // empty flush (flush_id = newest ID 10): no record, sequence unchanged
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 16'd10);
        exp_q.push_back(exp_retire(8'd2, 16'd8, 16'd5));
        cyc(1'b0, '0, '0, 1'b1, 16'd8, 1'b0, '0);

        // retire sequenced before a same-cycle flush of 9..10
        exp_q.push_back(pack_rec(1'b0, 8'd1, 1'b0, '0, '0, '0,
                                 1'b1, 16'd9, 16'd6, 1'b1, 16'd9, 16'd10, 16'd0));
        cyc(1'b0, '0, '0, 1'b1, 16'd9, 1'b1, 16'd8);
        exp_q.push_back(exp_retire(8'd1, 16'd10, 16'd9));
        cyc(1'b0, '0, '0, 1'b1, 16'd10, 1'b0, '0);
        idle(3);

        // overflow: 12 fetches with the consumer stalled
        rec_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) exp_q.push_back(exp_start((i == 0) ? 8'd4 : 8'd1, IW'(11 + i)));
            fetch();
        end
        #1;
        check_val("drop_state", 32'(dropping), 32'd1);
        check_val("full_valid", 32'(rec_valid), 32'd1);
        // consumer resumes; this fetch still sees a full FIFO and is counted
        rec_ready = 1'b1;
        fetch();
        // room now: marker counts 5 earlier drops plus this active cycle
        exp_q.push_back(pack_rec(1'b1, '0, 1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 16'd6));
        fetch();
        #1;
        check_val("drop_exit", 32'(dropping), 32'd0);
        exp_q.push_back(exp_start(8'd1, 16'd25));
        fetch();
        wait_drain(200);

        // reset mid-stream discards queued records
        rec_ready = 1'b0;
        fetch(); fetch(); fetch();
        rst = 1'b0;
        #1;
        check_val("midrst_valid", 32'(rec_valid), 32'd0);
        check_val("midrst_start_id", 32'(rec_start_id), 32'd0);
        rec_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("midrst_hold", 32'(rec_valid), 32'd0);
        rst = 1'b1;

        // fetches inside the synchroniser window are ignored
        fetch(); fetch();
        idle(300);
        exp_q.push_back(exp_start(8'd255, 16'd0));
        fetch();
        for (int i = 1; i <= 65535; i++) begin
            exp_q.push_back(exp_start(8'd1, IW'(i)));
            fetch();
        end
        exp_q.push_back(exp_start(8'd1, 16'd0));
        fetch();
        wait_drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
